// File: rtl/relm_uart_pkg.sv
// Shared constants and state encodings for the relm UART I/O peripheral.
package relm_uart_pkg;

  localparam int ST_RXV   = 0;
  localparam int ST_TXHV  = 1;
  localparam int ST_TXACT = 2;
  localparam int ST_OVR   = 3;
  localparam int ST_FRM   = 4;

  localparam int CMD_READ = 0;
  localparam int CMD_CLR  = 1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_e;

endpackage

// File: rtl/relm_uart_if.sv
// PE-facing PUSH/POP bus in the {flag, data} WD+1 word format.
interface relm_uart_if #(
  parameter int WD = 32
);
  logic [WD:0] push_d;
  logic        push_retry;
  logic [WD:0] pop_d;
  logic [WD:0] pop_q;

  modport master (output push_d, output pop_d, input push_retry, input pop_q);
  modport slave  (input push_d, input pop_d, output push_retry, output pop_q);
endinterface

// File: rtl/relm_uart_rx.sv
// 8N1 receiver: rxd synchronizer, mid-bit sampling FSM, one-cycle done/ferr pulses.
module relm_uart_rx
  import relm_uart_pkg::*;
#(
  parameter int CLKDIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       done,
  output logic       ferr
);

  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV / 2 - 1);

  logic          sync1, sync2;
  rx_state_e     state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    sh;
  logic          shift_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      state  <= RX_IDLE;
      cnt    <= '0;
      bitcnt <= '0;
    end else begin
      sync1  <= rxd;
      sync2  <= sync1;
      state  <= nxt;
      cnt    <= cnt_n;
      bitcnt <= bitcnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) sh <= {sync2, sh[7:1]};
  end

  // Start edge waits half a bit so every later sample lands mid-bit.
  always_comb begin
    nxt      = state;
    cnt_n    = cnt;
    bitcnt_n = bitcnt;
    shift_en = 1'b0;
    done     = 1'b0;
    ferr     = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!sync2) begin
          nxt   = RX_START;
          cnt_n = HALF_LAST;
        end
      end
      RX_START: begin
        if (cnt == '0) begin
          if (!sync2) begin
            nxt      = RX_DATA;
            cnt_n    = BIT_LAST;
            bitcnt_n = '0;
          end else begin
            nxt = RX_IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == '0) begin
          shift_en = 1'b1;
          cnt_n    = BIT_LAST;
          if (bitcnt == 3'd7) nxt = RX_STOP;
          else bitcnt_n = bitcnt + 3'd1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == '0) begin
          if (sync2) begin
            done = 1'b1;
            nxt  = RX_IDLE;
          end else begin
            ferr = 1'b1;
            nxt  = RX_WAIT;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      RX_WAIT: begin
        if (sync2) nxt = RX_IDLE;
      end
      default: nxt = RX_IDLE;
    endcase
  end

  assign rx_byte = sh;

endmodule

// File: rtl/relm_uart_io.sv
// UART peripheral on the relm PUSH/POP ports: PUSH feeds the transmitter, POP reads RX data or status.
module relm_uart_io
  import relm_uart_pkg::*;
#(
  parameter int WD     = 32,
  parameter int CLKDIV = 434
) (
  input  logic         clk,
  input  logic         rst_n,
  relm_uart_if.slave   bus,
  output logic         txd,
  input  logic         rxd
);

  localparam int CW = $clog2(CLKDIV);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKDIV - 1);

  tx_state_e     tx_state, tx_nxt;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic [7:0]    tx_hold;
  logic          tx_hv, tx_load, tx_active;
  logic          push_acc;

  logic [7:0]    rx_hold, rx_byte;
  logic          rx_v, ovr, frm;
  logic          rx_done, rx_ferr;
  logic          rd_take, st_clr, rx_store;
  logic [WD-1:0] status;
  logic          unused_ok;

  relm_uart_rx #(.CLKDIV(CLKDIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxd     (rxd),
    .rx_byte (rx_byte),
    .done    (rx_done),
    .ferr    (rx_ferr)
  );

  assign push_acc  = bus.push_d[WD] & ~tx_hv;
  assign rd_take   = bus.pop_d[WD] & bus.pop_d[CMD_READ] & rx_v;
  assign st_clr    = bus.pop_d[WD] & ~bus.pop_d[CMD_READ] & bus.pop_d[CMD_CLR];
  assign rx_store  = rx_done & (~rx_v | rd_take);
  assign tx_active = (tx_state != TX_IDLE);
  assign bus.push_retry = tx_hv;
  assign unused_ok = ^{bus.push_d[WD-1:8], bus.pop_d[WD-1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_hv    <= 1'b0;
      rx_v     <= 1'b0;
      ovr      <= 1'b0;
      frm      <= 1'b0;
    end else begin
      tx_state <= tx_nxt;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      if (push_acc)     tx_hv <= 1'b1;
      else if (tx_load) tx_hv <= 1'b0;
      // A byte landing on the same edge as a consuming read refills rx_v.
      if (rx_store)     rx_v <= 1'b1;
      else if (rd_take) rx_v <= 1'b0;
      if (rx_done && rx_v && !rd_take) ovr <= 1'b1;
      else if (st_clr)                 ovr <= 1'b0;
      if (rx_ferr)     frm <= 1'b1;
      else if (st_clr) frm <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh <= tx_sh_n;
    if (push_acc) tx_hold <= bus.push_d[7:0];
    if (rx_store) rx_hold <= rx_byte;
  end

  // STOP reloads straight into START when a byte is waiting, so frames abut.
  always_comb begin
    tx_nxt   = tx_state;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_load  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_hv) tx_load = 1'b1;
      end
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_nxt   = TX_DATA;
          tx_cnt_n = BIT_LAST;
          tx_bit_n = '0;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = BIT_LAST;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_bit == 3'd7) tx_nxt = TX_STOP;
          else tx_bit_n = tx_bit + 3'd1;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (tx_hv) tx_load = 1'b1;
          else tx_nxt = TX_IDLE;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      default: tx_nxt = TX_IDLE;
    endcase
    if (tx_load) begin
      tx_nxt   = TX_START;
      tx_cnt_n = BIT_LAST;
      tx_sh_n  = tx_hold;
    end
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START: txd = 1'b0;
      TX_DATA:  txd = tx_sh[0];
      default:  txd = 1'b1;
    endcase
  end

  always_comb begin
    status           = '0;
    status[ST_RXV]   = rx_v;
    status[ST_TXHV]  = tx_hv;
    status[ST_TXACT] = tx_active;
    status[ST_OVR]   = ovr;
    status[ST_FRM]   = frm;
    if (bus.pop_d[CMD_READ]) begin
      if (rx_v) bus.pop_q = {1'b0, {(WD-8){1'b0}}, rx_hold};
      else      bus.pop_q = {1'b1, {WD{1'b0}}};
    end else begin
      bus.pop_q = {1'b0, status};
    end
  end

endmodule

// File: tb/tb_relm_uart_io.sv
// Scoreboard bench for relm_uart_io: TX frame monitor and POP response monitor against queued expectations.
module tb_relm_uart_io;

  localparam int WD     = 32;
  localparam int CLKDIV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd, rxd;
  logic loop_en = 1'b0;
  logic rxd_drv = 1'b1;

  assign rxd = loop_en ? txd : rxd_drv;

  relm_uart_if #(.WD(WD)) bus ();

  relm_uart_io #(.WD(WD), .CLKDIV(CLKDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .txd   (txd),
    .rxd   (rxd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] b; int gap; } txexp_t;
  typedef struct { string name; logic [WD:0] v; } popexp_t;
  txexp_t  tx_q[$];
  popexp_t pop_exp_q[$];

  task automatic check(input string name, input logic [WD:0] act, input logic [WD:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // TX monitor: every bit must hold for CLKDIV cycles; frames are compared to the queue
  initial begin : tx_mon
    logic       prev;
    logic [9:0] fr;
    logic       bad, abort;
    int         st, last_start;
    txexp_t     e;
    prev = 1'b1;
    last_start = -1000;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !txd) begin
        bad = 1'b0;
        abort = 1'b0;
        st = cyc;
        fr = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CLKDIV; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n) abort = 1'b1;
            if (c == 0) fr[b] = txd;
            else if (txd !== fr[b]) bad = 1'b1;
          end
        end
        if (!abort) begin
          if (tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_frame: unexpected frame bits %b", fr);
          end else begin
            e = tx_q.pop_front();
            check_i("tx_frame", int'({bad, fr}), int'({1'b0, 1'b1, e.b, 1'b0}));
            if (e.gap >= 0) check_i("tx_gap", st - last_start, e.gap);
          end
        end
        last_start = st;
      end
      prev = txd;
    end
  end

  initial begin : pop_mon
    popexp_t p;
    forever begin
      @(negedge clk);
      #1;
      if (bus.pop_d[WD] === 1'b1) begin
        if (pop_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got %h expected no read", bus.pop_q);
        end else begin
          p = pop_exp_q.pop_front();
          check(p.name, bus.pop_q, p.v);
        end
      end
    end
  end

  task automatic push_byte(input logic [7:0] b, output int retries);
    retries = 0;
    @(negedge clk);
    bus.push_d = {1'b1, {(WD-8){1'b1}}, b};
    while (bus.push_retry !== 1'b0 && retries < 400) begin
      retries++;
      @(negedge clk);
    end
    if (retries >= 400) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: byte %h still retried after %0d cycles", b, retries);
    end else begin
      @(posedge clk);
    end
    #1 bus.push_d = '0;
  endtask

  task automatic pop(input string name, input logic [WD-1:0] cmd, input logic [WD:0] exp);
    popexp_t p;
    @(negedge clk);
    p.name = name;
    p.v = exp;
    pop_exp_q.push_back(p);
    bus.pop_d = {1'b1, cmd};
    @(posedge clk);
    #1 bus.pop_d = '0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (CLKDIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      repeat (CLKDIV) @(negedge clk);
    end
    rxd_drv = stopb;
    repeat (CLKDIV) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int r1, r2;
    bus.push_d = '0;
    bus.pop_d  = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check1("reset_txd", txd, 1'b1);
    check1("reset_retry", bus.push_retry, 1'b0);
    check("reset_status", bus.pop_q, '0);
    bus.pop_d = {{WD{1'b0}}, 1'b1};
    #1 check("reset_read", bus.pop_q, {1'b1, {WD{1'b0}}});
    bus.pop_d = '0;
    rst_n = 1'b1;

    // single frame 0x55
    tx_q.push_back('{8'h55, -1});
    push_byte(8'h55, r1);
    check1("t1_retry_after_accept", bus.push_retry, 1'b1);
    check1("t1_txd_before_start", txd, 1'b1);
    @(posedge clk);
    #1;
    check1("t1_retry_clear", bus.push_retry, 1'b0);
    check1("t1_start_bit", txd, 1'b0);
    wait_cyc(50);

    // three pushes back to back
    tx_q.push_back('{8'h01, -1});
    tx_q.push_back('{8'h02, 10 * CLKDIV});
    tx_q.push_back('{8'h03, 10 * CLKDIV});
    push_byte(8'h01, r1);
    check_i("t2_0x01_retries", r1, 0);
    push_byte(8'h02, r1);
    check_i("t2_0x02_retries", r1, 1);
    push_byte(8'h03, r2);
    check_i("t2_0x03_retries", r2, 10 * CLKDIV - 1);
    wait_cyc(100);

    // loopback receive and read
    loop_en = 1'b1;
    tx_q.push_back('{8'hA5, -1});
    push_byte(8'hA5, r1);
    wait_cyc(60);
    pop("t3_read", 32'h1, {1'b0, 32'h0000_00A5});
    pop("t3_status", 32'h0, {1'b0, 32'h0});

    // empty read retries, status untouched
    pop("t4_read_empty", 32'h1, {1'b1, 32'h0});
    pop("t4_status", 32'h0, {1'b0, 32'h0});

    // overrun
    tx_q.push_back('{8'h11, -1});
    tx_q.push_back('{8'h22, 10 * CLKDIV});
    push_byte(8'h11, r1);
    push_byte(8'h22, r1);
    wait_cyc(100);
    pop("t5_status_ovr", 32'h0, {1'b0, 32'h09});
    pop("t5_read_first", 32'h1, {1'b0, 32'h11});
    pop("t5_status_clr", 32'h2, {1'b0, 32'h08});
    pop("t5_status_after_clr", 32'h0, {1'b0, 32'h0});
    loop_en = 1'b0;

    // framing error
    send_rx(8'h3C, 1'b0);
    rxd_drv = 1'b0;
    repeat (2 * CLKDIV) @(negedge clk);
    rxd_drv = 1'b1;
    wait_cyc(10);
    pop("t6_status_frm", 32'h0, {1'b0, 32'h10});
    pop("t6_read_after_frm", 32'h1, {1'b1, 32'h0});

    // reset during a TX frame (third data bit of 0x5A is 0)
    push_byte(8'h5A, r1);
    wait_cyc(15);
    #2;
    check1("t6_txd_before_reset", txd, 1'b0);
    rst_n = 1'b0;
    #1;
    check1("t6_txd_in_reset", txd, 1'b1);
    check1("t6_retry_in_reset", bus.push_retry, 1'b0);
    check("t6_status_in_reset", bus.pop_q, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pop("t6_status_after_reset", 32'h0, {1'b0, 32'h0});
    wait_cyc(60);

    check_i("tx_queue_drained", tx_q.size(), 0);
    check_i("pop_queue_drained", pop_exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
